pipeline_hazard_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enable and flush inputs of pc, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
  - load-use hazards detected in ID/EX;
  - taken branches resolved in the MEM stage, from the buffered branch and alu_zero of EX/MEM;
  - a ready-handshake with data memory that freezes the whole pipeline while an access is outstanding.
- Counts stall cycles for performance monitoring and latches a sticky error on a memory timeout.

---
 rtl/pipeline_hazard_controller_pkg.sv | 13 +
 rtl/pipeline_hazard_controller_if.sv | 48 ++++
 rtl/pipeline_hazard_controller_hazard_compare.sv | 19 +
 rtl/pipeline_hazard_controller.sv | 114 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: the hazard FSM state encoding and the
// register-zero constant used by the load-use comparator.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Control bus between the hazard controller and the 5-stage datapath.
// master : the controller (reads hazard sources, drives enables/flushes)
// slave  : the datapath (drives hazard sources, reads enables/flushes)
// Signals: ID operand fields, EX load info, EX/MEM branch/memory flags,
// data-memory ready/req handshake, per-register write/flush controls,
// stall counter and sticky memory-timeout flag.
interface pipeline_hazard_controller_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [4:0]           id_rs;
  logic [4:0]           id_rt;
  logic                 id_uses_rt;
  logic                 ex_mem_read;
  logic [4:0]           ex_write_reg_addr;
  logic                 mem_branch;
  logic                 mem_alu_zero;
  logic                 mem_read;
  logic                 mem_write;
  logic                 dmem_ready;
  logic                 dmem_req;
  logic                 pc_write;
  logic                 pc_sel_branch;
  logic                 if_id_write;
  logic                 if_id_flush;
  logic                 id_ex_write;
  logic                 id_ex_flush;
  logic                 ex_mem_write;
  logic                 ex_mem_flush;
  logic                 mem_wb_write;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic                 mem_error;

  modport master (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg_addr,
           mem_branch, mem_alu_zero, mem_read, mem_write, dmem_ready,
    output dmem_req, pc_write, pc_sel_branch, if_id_write, if_id_flush,
           id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush,
           mem_wb_write, stall_cycles, mem_error
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg_addr,
           mem_branch, mem_alu_zero, mem_read, mem_write, dmem_ready,
    input  dmem_req, pc_write, pc_sel_branch, if_id_write, if_id_flush,
           id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush,
           mem_wb_write, stall_cycles, mem_error
  );
endinterface

// File: rtl/pipeline_hazard_controller_hazard_compare.sv
// Pure combinational load-use match between the instruction in EX and the
// source operands of the instruction in ID. Register $0 never matches.
// Ports: ex_mem_read, ex_write_reg_addr, id_rs, id_rt, id_uses_rt -> hazard.
module hazard_compare
  import pipeline_hazard_controller_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg_addr,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hazard
);
  always_comb begin
    hazard = ex_mem_read && (ex_write_reg_addr != REG_ZERO) &&
             ((ex_write_reg_addr == id_rs) ||
              (id_uses_rt && (ex_write_reg_addr == id_rt)));
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports: clk, rst (async, active-high) and a master modport of the control
// bus. Combines load-use stalls, MEM-stage taken-branch flushes and a
// data-memory ready handshake that freezes every pipeline register. Counts
// cycles with pc_write=0 (saturating) and raises a sticky mem_error when an
// access stays outstanding for MEM_TIMEOUT cycles in MEM_WAIT.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  pipeline_hazard_controller_if.master   bus
);
  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  hz_state_t            state;
  logic [TW-1:0]        tcnt;
  logic [CNT_WIDTH-1:0] stall_q;
  logic                 err_q;

  logic mem_access, taken, active, freeze, hazard;

  hazard_compare u_hazard_compare (
    .ex_mem_read       (bus.ex_mem_read),
    .ex_write_reg_addr (bus.ex_write_reg_addr),
    .id_rs             (bus.id_rs),
    .id_rt             (bus.id_rt),
    .id_uses_rt        (bus.id_uses_rt),
    .hazard            (hazard)
  );

  always_comb begin
    mem_access = bus.mem_read | bus.mem_write;
    taken      = bus.mem_branch & bus.mem_alu_zero;
    // Outputs are forced low while reset is held, not just after it.
    active     = !rst && (state != HALT);
    freeze     = active && mem_access && !bus.dmem_ready;

    bus.dmem_req      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_sel_branch = 1'b0;
    bus.if_id_write   = 1'b0;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_write   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.ex_mem_write  = 1'b0;
    bus.ex_mem_flush  = 1'b0;
    bus.mem_wb_write  = 1'b0;

    if (active) begin
      bus.dmem_req = mem_access;
      if (!freeze) begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_write  = 1'b1;
        bus.ex_mem_write = 1'b1;
        bus.mem_wb_write = 1'b1;
        if (taken) begin
          // The dependent instruction is flushed, so load-use is moot.
          bus.pc_sel_branch = 1'b1;
          bus.if_id_flush   = 1'b1;
          bus.id_ex_flush   = 1'b1;
          bus.ex_mem_flush  = 1'b1;
        end else if (hazard) begin
          bus.pc_write    = 1'b0;
          bus.if_id_write = 1'b0;
          bus.id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      tcnt    <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (freeze) begin
            state <= MEM_WAIT;
            tcnt  <= TW'(1);
          end
        end
        MEM_WAIT: begin
          // Leave as soon as the access is no longer blocking: normally
          // dmem_ready, but also a withdrawn request.
          if (!freeze) begin
            state <= RUN;
          end else if (tcnt == TW'(MEM_TIMEOUT)) begin
            state <= HALT;
            err_q <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase

      if (!bus.pc_write && (state != HALT) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.mem_error    = err_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a table of single-cycle
// input/output vectors applied from RUN, plus hand-written multi-cycle
// sequences for load-use, memory freeze, timeout/HALT and saturation.
module tb_pipeline_hazard_controller;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_WIDTH(CW)) bus ();

  pipeline_hazard_controller #(.MEM_TIMEOUT(64), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {dmem_req, pc_write, pc_sel_branch, if_id_write, if_id_flush,
  //  id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write}
  logic [9:0] outs;
  assign outs = {bus.dmem_req, bus.pc_write, bus.pc_sel_branch,
                 bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                 bus.id_ex_flush, bus.ex_mem_write, bus.ex_mem_flush,
                 bus.mem_wb_write};

  localparam logic [9:0] O_NORM   = 10'b0_1_0_1_0_1_0_1_0_1;
  localparam logic [9:0] O_NORM_R = 10'b1_1_0_1_0_1_0_1_0_1;
  localparam logic [9:0] O_LU     = 10'b0_0_0_0_0_1_1_1_0_1;
  localparam logic [9:0] O_LU_R   = 10'b1_0_0_0_0_1_1_1_0_1;
  localparam logic [9:0] O_BR     = 10'b0_1_1_1_1_1_1_1_1_1;
  localparam logic [9:0] O_FRZ    = 10'b1_0_0_0_0_0_0_0_0_0;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, ex_rd;
    logic [4:0] ex_wr;
    logic       br, zero, mrd, mwr, rdy;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_write_reg_addr = '0;
    bus.mem_branch = 1'b0; bus.mem_alu_zero = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_uses_rt = v.uses_rt;
    bus.ex_mem_read = v.ex_rd; bus.ex_write_reg_addr = v.ex_wr;
    bus.mem_branch = v.br; bus.mem_alu_zero = v.zero;
    bus.mem_read = v.mrd; bus.mem_write = v.mwr; bus.dmem_ready = v.rdy;
  endtask

  // Asynchronous reset pulse placed just after a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    //          name          rs  rt  urt exrd exwr br zr mrd mwr rdy exp
    vecs[0]  = '{"idle",       0,  0, 0,  0,   0,  0, 0, 0,  0,  0,  O_NORM};
    vecs[1]  = '{"lu_rs",      8,  0, 0,  1,   8,  0, 0, 0,  0,  0,  O_LU};
    vecs[2]  = '{"lu_rt",      3,  8, 1,  1,   8,  0, 0, 0,  0,  0,  O_LU};
    vecs[3]  = '{"rt_unused",  3,  8, 0,  1,   8,  0, 0, 0,  0,  0,  O_NORM};
    vecs[4]  = '{"load_r0",    0,  0, 1,  1,   0,  0, 0, 0,  0,  0,  O_NORM};
    vecs[5]  = '{"not_load",   8,  8, 1,  0,   8,  0, 0, 0,  0,  0,  O_NORM};
    vecs[6]  = '{"br_over_lu", 8,  0, 0,  1,   8,  1, 1, 0,  0,  0,  O_BR};
    vecs[7]  = '{"br_nt_lu",   8,  0, 0,  1,   8,  1, 0, 0,  0,  0,  O_LU};
    vecs[8]  = '{"frz_all",    8,  0, 0,  1,   8,  1, 1, 1,  0,  0,  O_FRZ};
    vecs[9]  = '{"mwr_ready",  0,  0, 0,  0,   0,  0, 0, 0,  1,  1,  O_NORM_R};
    vecs[10] = '{"mrd_rdy_lu", 5,  0, 0,  1,   5,  0, 0, 1,  0,  1,  O_LU_R};

    idle();
    // Reset held: every control low, counters clear.
    #2;
    bus.mem_read = 1'b1; bus.dmem_ready = 1'b1;
    #1;
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rst_err", 32'(bus.mem_error), 32'd0);

    // Table: each vector evaluated from RUN without a clock edge.
    for (int i = 0; i < 11; i++) begin
      pulse_reset();
      apply(vecs[i]);
      #1 chk(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      #1 idle();
    end

    // Load-use: exactly one bubble, then the load has moved to MEM.
    pulse_reset();
    apply(vecs[1]);
    #1 chk("lu_seq_c1", 32'(outs), 32'(O_LU));
    @(negedge clk);
    idle(); bus.mem_read = 1'b1; bus.dmem_ready = 1'b1;
    #1 chk("lu_seq_c2", 32'(outs), 32'(O_NORM_R));
    chk("lu_seq_stall", 32'(bus.stall_cycles), 32'd1);
    @(negedge clk);
    idle();
    #1 chk("lu_seq_stall2", 32'(bus.stall_cycles), 32'd1);

    // Memory freeze for 3 cycles, released on the 4th.
    pulse_reset();
    bus.mem_read = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("frz_c%0d", c), 32'(outs), 32'(O_FRZ));
      @(negedge clk);
    end
    bus.dmem_ready = 1'b1;
    #1 chk("frz_release", 32'(outs), 32'(O_NORM_R));
    @(negedge clk);
    idle(); bus.mem_read = 1'b1;
    #1 chk("frz_stall", 32'(bus.stall_cycles), 32'd3);
    // Back in RUN: a new unready access freezes again, no error.
    chk("frz_again", 32'(outs), 32'(O_FRZ));
    chk("frz_noerr", 32'(bus.mem_error), 32'd0);

    // Timeout: RUN cycle plus 64 MEM_WAIT cycles, then HALT.
    pulse_reset();
    bus.mem_write = 1'b1;
    n = 0;
    while (!bus.mem_error && n < 200) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("timeout_edges", 32'(n), 32'd65);
    @(negedge clk);
    bus.dmem_ready = 1'b1;
    #1 chk("halt_outs", 32'(outs), 32'd0);
    chk("halt_err", 32'(bus.mem_error), 32'd1);
    chk("halt_stall_sat", 32'(bus.stall_cycles), 32'd15);
    @(negedge clk);
    chk("halt_sticky", 32'(bus.mem_error), 32'd1);
    #1 rst = 1'b1;
    #1 chk("halt_async_clr", 32'(bus.mem_error), 32'd0);
    chk("halt_async_stall", 32'(bus.stall_cycles), 32'd0);
    rst = 1'b0;
    idle();
    #1 chk("halt_after_rst", 32'(outs), 32'(O_NORM));

    // Continuous load-use stall saturates the 4-bit counter at 15.
    pulse_reset();
    apply(vecs[2]);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 13) chk("sat_14", 32'(bus.stall_cycles), 32'd14);
    end
    chk("sat_15", 32'(bus.stall_cycles), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
